fifo_buffer_flags: RTL and testbench

//   Parametrised synchronous FIFO, successor to the basic 8-deep buffer. Adds occupancy

---
 rtl/fifo_buffer_flags_pkg.sv | 27 ++
 rtl/fifo_mem_dp.sv | 59 +++++
 rtl/fifo_buffer_flags.sv | 169 ++++++++++++++++
 tb/tb_fifo_buffer_flags.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_buffer_flags_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_buffer_flags_pkg
// Description : Shared sizing helpers and threshold range checks for the
//               flagged synchronous FIFO family.
//               Pointer and COUNT width is DEPTH_BITS+1; the extra bit is the
//               wrap bit, so the difference of two pointers covers 0..DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_buffer_flags_pkg;

    // Width of a read/write pointer, including the wrap bit.
    function automatic int ptr_width(input int depth_bits);
        return depth_bits + 1;
    endfunction

    // Legal ranges: almost-full in 1..DEPTH, almost-empty in 0..DEPTH-1.
    function automatic bit thresh_ok(input int afull, input int aempty,
                                     input int depth_bits);
        int depth;
        depth = 1 << depth_bits;
        return (afull >= 1) && (afull <= depth) &&
               (aempty >= 0) && (aempty <= depth - 1);
    endfunction

endpackage : fifo_buffer_flags_pkg
`default_nettype wire

// File: rtl/fifo_mem_dp.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem_dp
// Description : DEPTH x DATA_WIDTH storage array with one write port and one
//               read port. The read port is registered (read-before-write,
//               output reset to 0 and held when not reading) unless
//               FIFO_FWFT_EN is defined, in which case it is asynchronous.
// Ports       : clk, rst_n            clock / async active-low reset
//               i_wr_en/addr/data     write port
//               i_rd_en/addr          read port request
//               o_rd_data             read data
// Macro       : FIFO_FWFT_EN          selects the asynchronous read port
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // Storage is deliberately not reset.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign o_rd_data = r_mem[i_rd_addr];
`else
    logic [DATA_WIDTH-1:0] r_rd_q;

    // Same-address write in the same cycle is not forwarded: the reader
    // gets the old word, which is what a simultaneous pop on a full FIFO needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_q <= '0;
        end else if (i_rd_en) begin
            r_rd_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_q;
`endif

endmodule : fifo_mem_dp
`default_nettype wire

// File: rtl/fifo_buffer_flags.sv
`default_nettype none
// ============================================================================
// Module      : fifo_buffer_flags
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full/almost-empty flags, sticky
//               overflow/underflow flags and read-valid qualification.
// Ports       : clk, rst_n                      clock / async active-low reset
//               i_wr_en, i_wr_data              push
//               i_rd_en                         pop
//               i_clr_err                       clear sticky error flags
//               o_rd_data, o_rd_valid           read data and qualifier
//               o_full, o_empty                 COUNT==DEPTH / COUNT==0
//               o_almost_full, o_almost_empty   threshold flags
//               o_count                         occupancy 0..DEPTH
//               o_overflow, o_underflow         sticky error flags
// Macro       : FIFO_FWFT_EN  first-word-fall-through read mode when defined;
//               registered read with empty bypass when undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_buffer_flags
    import fifo_buffer_flags_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH_BITS    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [DEPTH_BITS:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int                 c_PTR_W     = ptr_width(DEPTH_BITS);
    localparam int                 c_DEPTH     = 1 << DEPTH_BITS;
    localparam logic [c_PTR_W-1:0] c_DEPTH_CNT = c_PTR_W'(c_DEPTH);
    localparam logic [c_PTR_W-1:0] c_AFULL     = c_PTR_W'(AFULL_THRESH);
    localparam logic [c_PTR_W-1:0] c_AEMPTY    = c_PTR_W'(AEMPTY_THRESH);

    generate
        if (!thresh_ok(AFULL_THRESH, AEMPTY_THRESH, DEPTH_BITS)) begin : g_thresh_check
            $error("fifo_buffer_flags: AFULL_THRESH/AEMPTY_THRESH out of range");
        end
    endgenerate

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [c_PTR_W-1:0]    w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_bypass;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic [DATA_WIDTH-1:0] w_mem_rd;

    // Modular subtraction of wrap-bit pointers gives 0..DEPTH directly.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == c_DEPTH_CNT);
    assign w_empty = (w_count == '0);

`ifdef FIFO_FWFT_EN
    // Nothing is visible yet on an empty FIFO, so a pop there is ignored
    // while the write still lands.
    assign w_bypass = 1'b0;
`else
    // Push and pop on an empty FIFO hand the word straight to the reader.
    assign w_bypass = i_wr_en & i_rd_en & w_empty;
`endif

    // A full FIFO still accepts a write when a pop frees a slot the same cycle.
    assign w_wr_acc  = i_wr_en & (~w_full | i_rd_en) & ~w_bypass;
    assign w_rd_acc  = i_rd_en & ~w_empty;
    assign w_ovf_set = i_wr_en & w_full & ~i_rd_en;
    assign w_udf_set = i_rd_en & w_empty & ~i_wr_en;

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_BITS)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[DEPTH_BITS-1:0]),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr[DEPTH_BITS-1:0]),
        .o_rd_data (w_mem_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // A fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set | (r_overflow  & ~i_clr_err);
            r_underflow <= w_udf_set | (r_underflow & ~i_clr_err);
        end
    end

`ifdef FIFO_FWFT_EN
    assign o_rd_valid = ~w_empty;
    assign o_rd_data  = w_empty ? '0 : w_mem_rd;
`else
    logic                  r_rd_valid;
    logic                  r_byp_sel;
    logic [DATA_WIDTH-1:0] r_byp_data;

    // r_byp_sel picks the bypassed word until the next real pop reloads the
    // memory read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_rd_valid <= w_rd_acc | w_bypass;
            if (w_bypass) begin
                r_byp_sel  <= 1'b1;
                r_byp_data <= i_wr_data;
            end else if (w_rd_acc) begin
                r_byp_sel  <= 1'b0;
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_byp_sel ? r_byp_data : w_mem_rd;
`endif

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (w_count >= c_AFULL);
    assign o_almost_empty = (w_count <= c_AEMPTY);
    assign o_count        = w_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule : fifo_buffer_flags
`default_nettype wire

// File: tb/tb_fifo_buffer_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_buffer_flags
// Description : Directed self-checking bench for fifo_buffer_flags in its
//               default (registered-read) configuration, DEPTH = 16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_buffer_flags;

    logic       clk;
    logic       rst_n;
    logic       i_wr_en;
    logic [7:0] i_wr_data;
    logic       i_rd_en;
    logic       i_clr_err;
    logic [7:0] o_rd_data;
    logic       o_rd_valid;
    logic       o_full;
    logic       o_empty;
    logic       o_almost_full;
    logic       o_almost_empty;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       o_underflow;

    int n_cmp = 0;
    int n_err = 0;

    fifo_buffer_flags #(
        .DATA_WIDTH    (8),
        .DEPTH_BITS    (4),
        .AFULL_THRESH  (12),
        .AEMPTY_THRESH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_wr_en        (i_wr_en),
        .i_wr_data      (i_wr_data),
        .i_rd_en        (i_rd_en),
        .i_clr_err      (i_clr_err),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        i_wr_en   = wr;
        i_wr_data = d;
        i_rd_en   = rd;
        i_clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(o_count), 32'd0);
        chk({tag, "_empty"}, 32'(o_empty), 32'd1);
        chk({tag, "_aempty"}, 32'(o_almost_empty), 32'd1);
        chk({tag, "_full"}, 32'(o_full), 32'd0);
        chk({tag, "_afull"}, 32'(o_almost_full), 32'd0);
        chk({tag, "_rdvalid"}, 32'(o_rd_valid), 32'd0);
        chk({tag, "_rddata"}, 32'(o_rd_data), 32'd0);
        chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
        chk({tag, "_udf"}, 32'(o_underflow), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_data = 8'h00;
        i_rd_en   = 1'b0;
        i_clr_err = 1'b0;
        #3;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Fill with 0x00..0x0F.
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 8'(k - 1), 1'b0, 1'b0);
            chk("fill_count", 32'(o_count), 32'(k));
            chk("fill_afull", 32'(o_almost_full), 32'(k >= 12));
            chk("fill_aempty", 32'(o_almost_empty), 32'(k <= 2));
            chk("fill_full", 32'(o_full), 32'(k == 16));
        end

        // 2. Write while full is dropped and sets OVERFLOW; CLR_ERR clears it.
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        chk("ovf_count", 32'(o_count), 32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(o_overflow), 32'd0);

        // 3. Drain in order, then read on empty.
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data", 32'(o_rd_data), 32'(k));
            chk("drain_valid", 32'(o_rd_valid), 32'd1);
            chk("drain_count", 32'(o_count), 32'(15 - k));
        end
        chk("drain_empty", 32'(o_empty), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_set", 32'(o_underflow), 32'd1);
        chk("udf_valid", 32'(o_rd_valid), 32'd0);
        chk("udf_hold", 32'(o_rd_data), 32'h0F);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("udf_clr", 32'(o_underflow), 32'd0);

        // 4. Pointer wrap at COUNT=8 with simultaneous push/pop.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
        end
        chk("wrap_pre_count", 32'(o_count), 32'd8);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 8'(8'h28 + k), 1'b1, 1'b0);
            chk("wrap_data", 32'(o_rd_data), 32'(8'h20 + k));
            chk("wrap_count", 32'(o_count), 32'd8);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_tail", 32'(o_rd_data), 32'(8'h48 + k));
        end
        chk("wrap_empty", 32'(o_empty), 32'd1);

        // 5. Push+pop on empty bypasses storage.
        step(1'b1, 8'h5C, 1'b1, 1'b0);
        chk("byp_data", 32'(o_rd_data), 32'h5C);
        chk("byp_valid", 32'(o_rd_valid), 32'd1);
        chk("byp_count", 32'(o_count), 32'd0);
        chk("byp_udf", 32'(o_underflow), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("byp_valid_drop", 32'(o_rd_valid), 32'd0);
        chk("byp_hold", 32'(o_rd_data), 32'h5C);

        // 6. Async reset mid-burst at COUNT=7 with UNDERFLOW set.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_udf", 32'(o_underflow), 32'd1);
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
        end
        chk("pre_rst_count", 32'(o_count), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        @(negedge clk);
        i_wr_en = 1'b0;
        rst_n   = 1'b1;

        // 7. Push+pop on full: both accepted, no OVERFLOW; error beats clear.
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
        end
        step(1'b1, 8'h99, 1'b1, 1'b0);
        chk("fullrw_count", 32'(o_count), 32'd16);
        chk("fullrw_ovf", 32'(o_overflow), 32'd0);
        chk("fullrw_data", 32'(o_rd_data), 32'h30);
        chk("fullrw_full", 32'(o_full), 32'd1);
        step(1'b1, 8'hAB, 1'b0, 1'b1);
        chk("clr_vs_set", 32'(o_overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_only", 32'(o_overflow), 32'd0);
        chk("clr_count", 32'(o_count), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo_buffer_flags
`default_nettype wire
